reg_file_mp: RTL and testbench
==============================

Name: reg_file_mp

Overview:
- Parametrised successor to the core's integer register file: configurable width, depth and read-port count, with one write port.
- x0 is hardwired to zero; there are no preloaded constants.
- A sequential clear engine zeroes the array one entry per cycle after reset or on request, and reports `busy`.
- Sits in the decode/writeback path of the RV32I core, with the read ports feeding operand muxes and the write port fed by writeback.

Parameters:
- XLEN, 32, data width in bits.
- NREGS, 32, number of architectural registers; power of two, ≥ 2. AW = $clog2(NREGS).
- NRD, 2, number of read ports, ≥ 1.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous, active-high reset.
- rd_addr  in  NRD*AW  read addresses; port k uses bits [k*AW +: AW].
- rd_data  out  NRD*XLEN  read data; port k uses bits [k*XLEN +: XLEN]; combinational.
- wr_en  in  1  write enable.
- wr_addr  in  AW  write address.
- wr_data  in  XLEN  write data.
- clr_req  in  1  request a full clear sweep; level-sampled in IDLE only.
- busy  out  1  clear sweep in progress.
- wr_drop  out  1  registered one-cycle pulse: a write was discarded because busy.

Behaviour:
- FSM states:
  - CLEAR: sweep in progress.
  - IDLE: normal operation.
- Reset (rst=1 at posedge):
  - state←CLEAR, clr_idx←1, wr_drop←0.
  - The array is not touched in the reset cycle.
  - busy=1 combinationally while state==CLEAR.
- CLEAR:
  - Each cycle, reg[clr_idx]←0 and clr_idx increments.
  - When clr_idx==NREGS-1 is written, state←IDLE next cycle.
  - busy is therefore high for exactly NREGS-1 cycles after the rst cycle (31 with defaults).
- IDLE:
  - clr_req=1 → state←CLEAR, clr_idx←1 next cycle.
  - Any write in that same cycle is still performed.
- Writes:
  - In IDLE, wr_en=1 with wr_addr≠0 → reg[wr_addr]←wr_data at posedge.
  - wr_addr==0 is silently ignored; it is not counted as a drop.
- Writes while busy:
  - The write is discarded and wr_drop=1 on the following cycle.
  - wr_drop is otherwise 0 and is cleared by rst.
- Reads:
  - rd_data[k] = 0 if rd_addr[k]==0.
  - rd_data[k] = 0 for all ports while busy, regardless of the sweep position.
  - Otherwise rd_data[k] = reg[rd_addr[k]].
  - Zero cycles of latency (asynchronous read).
- x0: no physical storage is required for index 0; it always reads as 0.
- Reset mid-sweep restarts the sweep from index 1.
- clr_req asserted while busy is ignored; sweeps are never queued.
- The array contents are undefined before the first completed sweep. The forced-zero reads hide this from consumers.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined:
  - Write-to-read forwarding applies when wr_en=1, !busy, wr_addr≠0 and rd_addr[k]==wr_addr.
  - In that case rd_data[k]=wr_data in the same cycle.
  - Each read port is checked independently.
- Undefined:
  - rd_data reflects the array only.
  - A written value becomes visible the cycle after the write edge.
- The x0 and busy zero-forcing rules take precedence over the bypass in both builds.

Test Plan:
- Reset and sweep: pulse rst for 1 cycle.
  - busy=1 for exactly 31 cycles, then 0.
  - All reads return 0 throughout; wr_drop=0.
- Basic write/read:
  - After the sweep, write x5←0xDEADBEEF, then x31←0x12345678.
  - Next cycle: rd_addr0=5 gives 0xDEADBEEF, rd_addr1=31 gives 0x12345678.
- x0 protection:
  - Write x0←0xFFFFFFFF.
  - rd_addr0=0 gives 0; wr_drop stays 0.
- Drop during clear:
  - Assert clr_req, then write x3←0xA5A5A5A5 on the second busy cycle.
  - wr_drop=1 for one cycle.
  - After busy falls, x3 reads 0; a prior x5 value also reads 0.
- Same-cycle read/write:
  - Write x7←0x00C0FFEE with rd_addr0=7.
  - Bypass build: rd_data0=0x00C0FFEE in the same cycle.
  - Non-bypass build: old value (0) in the same cycle, 0x00C0FFEE next cycle.
- Reset mid-sweep:
  - Assert rst on the 10th busy cycle.
  - busy stays high for 31 further cycles, then all registers read 0.

Source files
------------

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised integer register file for the RV32I decode/writeback path.
// NRD combinational read ports, one write port, x0 hardwired to zero.
// A sequential clear engine zeroes entries 1..NREGS-1 (one per cycle) after reset
// or on clr_req. While it runs, busy is high, reads return zero and writes are dropped.
// Optional feature: define REGFILE_BYPASS_EN to forward the write port to matching read ports.
module reg_file_mp #(
  parameter int XLEN  = 32,
  parameter int NREGS = 32,
  parameter int NRD   = 2,
  localparam int AW   = $clog2(NREGS)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRD*AW-1:0]   rd_addr,
  output logic [NRD*XLEN-1:0] rd_data,
  input  logic                wr_en,
  input  logic [AW-1:0]       wr_addr,
  input  logic [XLEN-1:0]     wr_data,
  input  logic                clr_req,
  output logic                busy,
  output logic                wr_drop
);

  typedef enum logic {
    CLEAR = 1'b0,
    IDLE  = 1'b1
  } state_t;

  state_t        state;
  logic [AW-1:0] clr_idx;

  // Entry 0 is never written; reads of x0 are forced to zero below.
  logic [XLEN-1:0] mem [0:NREGS-1];

  assign busy = (state == CLEAR);

  // Sweep sequencing and the write-drop pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= CLEAR;
      clr_idx <= AW'(1);
      wr_drop <= 1'b0;
    end else begin
      // A discarded write to x0 is indistinguishable from an ignored one, so it is not flagged.
      wr_drop <= (state == CLEAR) && wr_en && (wr_addr != '0);
      case (state)
        CLEAR: begin
          clr_idx <= clr_idx + AW'(1);
          if (clr_idx == AW'(NREGS - 1)) begin
            state <= IDLE;
          end
        end
        IDLE: begin
          if (clr_req) begin
            state   <= CLEAR;
            clr_idx <= AW'(1);
          end
        end
        default: state <= CLEAR;
      endcase
    end
  end

  // Array write: the sweep owns the port while clearing; the reset cycle leaves the array alone.
  always_ff @(posedge clk) begin
    if (!rst) begin
      if (state == CLEAR) begin
        mem[clr_idx] <= '0;
      end else if (wr_en && (wr_addr != '0)) begin
        mem[wr_addr] <= wr_data;
      end
    end
  end

  generate
    for (genvar gi = 0; gi < NRD; gi++) begin : g_rd
      logic [AW-1:0] addr;
      assign addr = rd_addr[gi*AW +: AW];

      // Read port: zero for x0 or mid-sweep (hides undefined contents), else array or bypass.
      always_comb begin
        rd_data[gi*XLEN +: XLEN] = '0;
        if (!busy && (addr != '0)) begin
`ifdef REGFILE_BYPASS_EN
          if (wr_en && (wr_addr == addr)) begin
            rd_data[gi*XLEN +: XLEN] = wr_data;
          end else begin
            rd_data[gi*XLEN +: XLEN] = mem[addr];
          end
`else
          rd_data[gi*XLEN +: XLEN] = mem[addr];
`endif
        end
      end
    end
  endgenerate

endmodule

// File: tb/tb_reg_file_mp.sv
// Self-checking bench for reg_file_mp (default parameters: 32 x 32 bits, 2 read ports).
// Reference model: an array of register values plus a count of remaining busy cycles;
// the sweep is modelled as "everything reads zero until it ends, then all entries are zero".
module tb_reg_file_mp;

  localparam int XLEN  = 32;
  localparam int NREGS = 32;
  localparam int NRD   = 2;
  localparam int AW    = 5;
`ifdef REGFILE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic                clk = 1'b0;
  logic                rst = 1'b0;
  logic [NRD*AW-1:0]   rd_addr = '0;
  logic [NRD*XLEN-1:0] rd_data;
  logic                wr_en = 1'b0;
  logic [AW-1:0]       wr_addr = '0;
  logic [XLEN-1:0]     wr_data = '0;
  logic                clr_req = 1'b0;
  logic                busy;
  logic                wr_drop;

  reg_file_mp #(.XLEN(XLEN), .NREGS(NREGS), .NRD(NRD)) dut (
    .clk     (clk),
    .rst     (rst),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .clr_req (clr_req),
    .busy    (busy),
    .wr_drop (wr_drop)
  );

  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  logic [XLEN-1:0] model [NREGS];
  int              busy_left = 0;
  logic            drop_exp  = 1'b0;

  task automatic check(input string tag, input logic [XLEN-1:0] obs, input logic [XLEN-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, clock, advance the model.
  task automatic cycle(input logic r, input logic c, input logic we, input logic [AW-1:0] wa,
                       input logic [XLEN-1:0] wd, input logic [AW-1:0] a0, input logic [AW-1:0] a1);
    logic [AW-1:0]   a;
    logic [XLEN-1:0] exp;
    rst = r; clr_req = c; wr_en = we; wr_addr = wa; wr_data = wd;
    rd_addr = {a1, a0};
    #1;
    check("busy", {31'd0, busy}, {31'd0, busy_left > 0});
    check("wr_drop", {31'd0, wr_drop}, {31'd0, drop_exp});
    for (int k = 0; k < NRD; k++) begin
      a = (k == 0) ? a0 : a1;
      if (busy_left > 0 || a == 0) exp = '0;
      else if (BYP && we && wa == a) exp = wd;
      else exp = model[a];
      check($sformatf("rd%0d[x%0d]", k, a), rd_data[k*XLEN +: XLEN], exp);
    end
    $display("cyc rst=%0b clr=%0b we=%0b wa=%0d wd=%h a0=%0d a1=%0d busy=%0b drop=%0b rd0=%h rd1=%h",
             r, c, we, wa, wd, a0, a1, busy, wr_drop, rd_data[0 +: XLEN], rd_data[XLEN +: XLEN]);
    @(posedge clk);
    if (r) begin
      busy_left = NREGS - 1;
      drop_exp  = 1'b0;
    end else begin
      drop_exp = (busy_left > 0) && we && (wa != 0);
      if (busy_left > 0) begin
        busy_left--;
        if (busy_left == 0) begin
          for (int i = 0; i < NREGS; i++) model[i] = '0;
        end
      end else begin
        if (we && wa != 0) model[wa] = wd;
        if (c) busy_left = NREGS - 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic idle_cycles(input int n);
    for (int i = 0; i < n; i++)
      cycle(1'b0, 1'b0, 1'b0, '0, '0, AW'($urandom_range(0, NREGS-1)), AW'($urandom_range(0, NREGS-1)));
  endtask

  initial begin
    for (int i = 0; i < NREGS; i++) model[i] = '0;
    @(negedge clk);
    // Initial reset: outputs are unknown before it, so nothing is checked here.
    rst = 1'b1;
    @(posedge clk);
    busy_left = NREGS - 1;
    drop_exp  = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    // Sweep: busy for exactly 31 cycles, reads zero throughout.
    idle_cycles(NREGS - 1);
    idle_cycles(2);

    // Basic write/read.
    cycle(1'b0, 1'b0, 1'b1, 5'd5,  32'hDEADBEEF, 5'd0, 5'd0);
    cycle(1'b0, 1'b0, 1'b1, 5'd31, 32'h12345678, 5'd5, 5'd1);
    cycle(1'b0, 1'b0, 1'b0, 5'd0,  32'h0,        5'd5, 5'd31);

    // x0 protection.
    cycle(1'b0, 1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5);
    cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        5'd0, 5'd31);

    // Drop during clear: second busy cycle writes x3.
    cycle(1'b0, 1'b1, 1'b0, 5'd0, 32'h0,        5'd5, 5'd3);
    cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        5'd5, 5'd3);
    cycle(1'b0, 1'b0, 1'b1, 5'd3, 32'hA5A5A5A5, 5'd3, 5'd5);
    idle_cycles(NREGS - 1);
    cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 5'd3, 5'd5);

    // Same-cycle read/write of x7.
    cycle(1'b0, 1'b0, 1'b1, 5'd7, 32'h00C0FFEE, 5'd7, 5'd7);
    cycle(1'b0, 1'b0, 1'b0, 5'd0, 32'h0,        5'd7, 5'd0);

    // Reset on the 10th busy cycle restarts the sweep.
    cycle(1'b0, 1'b0, 1'b1, 5'd9, 32'h99999999, 5'd9, 5'd7);
    cycle(1'b0, 1'b1, 1'b0, 5'd0, 32'h0, 5'd9, 5'd7);
    idle_cycles(9);
    cycle(1'b1, 1'b0, 1'b0, 5'd0, 32'h0, 5'd9, 5'd7);
    idle_cycles(NREGS - 1);
    for (int i = 0; i < NREGS; i += 2)
      cycle(1'b0, 1'b0, 1'b0, '0, '0, AW'(i), AW'(i + 1));

    // Randomised traffic: writes, reads, occasional clears and resets.
    for (int n = 0; n < 600; n++) begin
      cycle(($urandom_range(0, 149) == 0), ($urandom_range(0, 39) == 0),
            $urandom_range(0, 1) == 1, AW'($urandom_range(0, NREGS-1)), $urandom,
            AW'($urandom_range(0, NREGS-1)), AW'($urandom_range(0, NREGS-1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
